kamus_lsu: RTL and testbench
============================

# kamus_lsu

Parametrised load/store unit replacing the combinational MEM-stage data path. It accepts one memory operation at a time from the EX/MEM boundary and performs byte-lane alignment, byte-enable generation, and correct sign/zero extension. It runs a req/gnt/rvalid handshake with the L1 data cache, which may take any number of cycles. It stalls the pipeline while busy, supports kill (flush) mid-transaction, and delivers a registered, single-cycle result to WB.

## Interface
- `XLEN`, 32: data width; legal values are 32 and 64. LD/SD/LWU are legal only when `XLEN`=64.
- `ADDR_W`, 32: byte-address width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  operation present from EX/MEM.
- `op_i`  in  `lsu_op_e`  operation: NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD.
- `addr_i`  in  `ADDR_W`  byte address (EX result).
- `wdata_i`  in  `XLEN`  store data (rs2), right-justified.
- `rd_addr_i`  in  5  destination register.
- `kill_i`  in  1  flush the current operation.
- `busy_o`  out  1  stall request to pipeline.
- `done_valid_o`  out  1  one-cycle result strobe to WB.
- `rdata_o`  out  `XLEN`  extended load data; 0 for stores and errors.
- `rd_addr_o`  out  5  rd of the completed operation.
- `misaligned_o`  out  1  misaligned-access flag, qualified by `done_valid_o`.
- `bus_err_o`  out  1  memory error flag, qualified by `done_valid_o`.
- `dmem_req_o`  out  1  request to L1D.
- `dmem_we_o`  out  1  write enable.
- `dmem_be_o`  out  `XLEN`/8  byte enables.
- `dmem_addr_o`  out  `ADDR_W`  word-aligned address; low log2(`XLEN`/8) bits are zero.
- `dmem_wdata_o`  out  `XLEN`  lane-aligned store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  response valid; asserted for writes too.
- `dmem_rdata_i`  in  `XLEN`  read data.
- `dmem_err_i`  in  1  error, qualified by `dmem_rvalid_i`.

## Operation
- **States:** IDLE, REQ, RESP, DRAIN, ERR.
- **Accept:** an operation is accepted in IDLE when `req_valid_i`=1, `op_i`≠NONE and `kill_i`=0.
  - Accept registers op, addr offset, rd, aligned address, byte enables and aligned wdata.
- **Misalignment rules:** H needs `addr`[0]=0; W needs `addr`[1:0]=0; D needs `addr`[2:0]=0. B is never misaligned.
  - A misaligned operation goes IDLE→ERR and makes no memory access.
  - ERR→IDLE the next cycle with `done_valid_o`=1, `misaligned_o`=1, `rdata_o`=0.
- **REQ:** `dmem_req_o`=1 and all dmem outputs are held stable. On `dmem_gnt_i` go to RESP. On `kill_i` go to IDLE; withdrawing before grant is permitted by L1D.
- **RESP:** on `dmem_rvalid_i` go to IDLE and register the result: `done_valid_o`=1, `bus_err_o`=`dmem_err_i`.
  - Load: shift `dmem_rdata_i` right by offset×8, then extend. B/H/W are sign-extended; BU/HU/WU are zero-extended.
  - If `dmem_err_i`=1, `rdata_o`=0.
- **Kill in RESP:** go to DRAIN. DRAIN waits for `dmem_rvalid_i`, discards it (no `done_valid_o`), then goes to IDLE.
- **Store lanes:** `dmem_wdata_o` = wdata shifted left by offset×8. `dmem_be_o` = (1,3,0xF,0xFF per size) << offset.
- **busy_o:** 1 when state≠IDLE, or in IDLE when accepting. `kill_i` overrides; the pipeline drops the killed op.
- **kill_i in IDLE or ERR:** no effect on ERR completion (ERR is not memory-visible). `done_valid_o` is suppressed if `kill_i` is high in the ERR cycle.

## Timing
- **Reset:** state=IDLE; `busy_o` is 0 only when idle with no request. All other outputs are 0: `done_valid_o`, `rdata_o`, `rd_addr_o`, `misaligned_o`, `bus_err_o`, `dmem_*`.
- **Fastest load/store:** accept at T, `dmem_req_o`+`dmem_gnt_i` at T+1, `dmem_rvalid_i` at T+2, `done_valid_o` at T+3. `busy_o` is high T..T+2 and low at T+3.
- **Misaligned:** accept at T, `done_valid_o` at T+2.
- **Back-to-back:** a new op may be accepted in the cycle `done_valid_o` is high.
- **Ignored responses:** `dmem_gnt_i` outside REQ and `dmem_rvalid_i` in IDLE are ignored.
- **Reset mid-operation:** return to IDLE immediately, with no response drained. L1D is reset with the core.

## Structure
- **kamus_pkg:** add `lsu_op_e`, `lsu_state_e`, and a size-decode helper function returning byte count.
- **Sub-module `kamus_lsu_align`:** purely combinational. Two paths: wdata/offset/size → lane data and byte enables; rdata/offset/size/unsigned → extended data.
- **Top:** `kamus_lsu` holds the FSM and registers.

## Test plan
- **LB:** LB at addr 0x1003, rdata 0x80FF_0000 → `dmem_addr_o`=0x1000, `dmem_be_o`=0x8, `rdata_o`=0xFFFF_FF80, done at T+3.
- **LHU:** LHU at 0x2002, rdata 0xBEEF_1234 → `rdata_o`=0x0000_BEEF.
- **SH:** SH at 0x3002, wdata 0x0000_ABCD → `dmem_wdata_o`=0xABCD_0000, `dmem_be_o`=0xC, `dmem_we_o`=1.
- **Misaligned LW:** LW at 0x4001 → no `dmem_req_o`, `done_valid_o`+`misaligned_o` at T+2.
- **Delayed grant, error response:** gnt withheld 3 cycles → outputs stable while `busy_o`=1. A response with `dmem_err_i`=1 → `bus_err_o`=1, `rdata_o`=0.
- **Kill after grant:** `kill_i` in RESP, rvalid 2 cycles later → no `done_valid_o`. The next LW is accepted only after DRAIN and completes normally.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types and decode helpers for the kamus load/store unit.
package kamus_pkg;

  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_RESP, ST_DRAIN, ST_ERR
  } lsu_state_e;

  function automatic logic [3:0] lsu_size_bytes(input lsu_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'd1;
      OP_LH, OP_LHU, OP_SH: return 4'd2;
      OP_LW, OP_LWU, OP_SW: return 4'd4;
      OP_LD, OP_SD:         return 4'd8;
      default:              return 4'd0;
    endcase
  endfunction

  function automatic logic lsu_is_store(input lsu_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic lsu_is_unsigned(input lsu_op_e op);
    return op inside {OP_LBU, OP_LHU, OP_LWU};
  endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane steering: store data/byte enables toward memory and
// load data extraction plus sign/zero extension back toward the core.
module kamus_lsu_align #(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [OFF_W-1:0] w_off_i,
  input  logic [3:0]       w_size_i,
  output logic [XLEN-1:0]  lane_wdata_o,
  output logic [NB-1:0]    be_o,
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] r_off_i,
  input  logic [3:0]       r_size_i,
  input  logic             r_unsigned_i,
  output logic [XLEN-1:0]  ext_rdata_o
);

  logic [NB-1:0]   be_base;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  always_comb begin
    case (w_size_i)
      4'd1:    be_base = NB'(1);
      4'd2:    be_base = NB'(3);
      4'd4:    be_base = NB'(15);
      default: be_base = '1;
    endcase
    be_o         = be_base << w_off_i;
    lane_wdata_o = wdata_i << {w_off_i, 3'b000};

    shifted = rdata_i >> {r_off_i, 3'b000};
    case (r_size_i)
      4'd1: begin
        mask = XLEN'(32'hFF);
        sign = shifted[7];
      end
      4'd2: begin
        mask = XLEN'(32'hFFFF);
        sign = shifted[15];
      end
      4'd4: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    // Sign fill covers every bit above the loaded field.
    ext_rdata_o = (shifted & mask) | ((sign && !r_unsigned_i) ? ~mask : '0);
  end

endmodule

// File: rtl/kamus_lsu.sv
// Load/store unit FSM: one operation in flight, L1D req/gnt/rvalid handshake.
//   IDLE  | waiting for an operation
//   REQ   | request presented to L1D, outputs held until grant
//   RESP  | granted, waiting for rvalid
//   DRAIN | killed after grant, swallowing the outstanding response
//   ERR   | misaligned or illegal op, reports without touching memory
module kamus_lsu
  import kamus_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  lsu_op_e             op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                kill_i,
  output logic                busy_o,
  output logic                done_valid_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic [4:0]          rd_addr_o,
  output logic                misaligned_o,
  output logic                bus_err_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  input  logic                dmem_err_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e         state_q, state_d;
  lsu_op_e            op_q, op_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [4:0]         rd_q, rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [NB-1:0]      be_q, be_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               done_q, done_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic [4:0]         rd_out_q, rd_out_d;
  logic               mis_q, mis_d;
  logic               berr_q, berr_d;

  logic               accept, illegal, misaligned_in, in_req;
  logic [3:0]         size_in;
  logic [NB-1:0]      lane_be;
  logic [XLEN-1:0]    lane_wdata, ext_rdata;

  assign size_in = lsu_size_bytes(op_i);
  assign accept  = req_valid_i && (op_i != OP_NONE) && !kill_i;
  // Doubleword ops and LWU have no meaning on a 32-bit datapath; report them
  // through the same no-memory-access error path as misalignment.
  assign illegal = (XLEN == 32) && (op_i inside {OP_LD, OP_SD, OP_LWU});
  assign misaligned_in = illegal || ((addr_i[2:0] & (size_in[2:0] - 3'd1)) != 3'b000);

  kamus_lsu_align #(.XLEN(XLEN)) u_align (
    .wdata_i      (wdata_i),
    .w_off_i      (addr_i[OFF_W-1:0]),
    .w_size_i     (size_in),
    .lane_wdata_o (lane_wdata),
    .be_o         (lane_be),
    .rdata_i      (dmem_rdata_i),
    .r_off_i      (off_q),
    .r_size_i     (lsu_size_bytes(op_q)),
    .r_unsigned_i (lsu_is_unsigned(op_q)),
    .ext_rdata_o  (ext_rdata)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    off_d    = off_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    rdata_d  = '0;
    rd_out_d = '0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_i;
          off_d   = addr_i[OFF_W-1:0];
          rd_d    = rd_addr_i;
          addr_d  = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          be_d    = lane_be;
          wdata_d = lane_wdata;
          state_d = misaligned_in ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        // A grant in the kill cycle still owes us a response.
        if (dmem_gnt_i)  state_d = kill_i ? ST_DRAIN : ST_RESP;
        else if (kill_i) state_d = ST_IDLE;
      end
      ST_RESP: begin
        if (kill_i) begin
          state_d = dmem_rvalid_i ? ST_IDLE : ST_DRAIN;
        end else if (dmem_rvalid_i) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          rd_out_d = rd_q;
          berr_d   = dmem_err_i;
          rdata_d  = (dmem_err_i || lsu_is_store(op_q)) ? '0 : ext_rdata;
        end
      end
      ST_DRAIN: begin
        if (dmem_rvalid_i) state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d  = ST_IDLE;
        done_d   = !kill_i;
        mis_d    = !kill_i;
        rd_out_d = kill_i ? 5'd0 : rd_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      off_q    <= '0;
      rd_q     <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      rd_out_q <= '0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      rd_out_q <= rd_out_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign in_req       = (state_q == ST_REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && lsu_is_store(op_q);
  assign dmem_be_o    = in_req ? be_q : '0;
  assign dmem_addr_o  = in_req ? addr_q : '0;
  assign dmem_wdata_o = in_req ? wdata_q : '0;

  assign busy_o       = !kill_i && ((state_q != ST_IDLE) || (req_valid_i && (op_i != OP_NONE)));
  assign done_valid_o = done_q;
  assign rdata_o      = rdata_q;
  assign rd_addr_o    = rd_out_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_kamus_lsu.sv
// Directed testbench for kamus_lsu (XLEN=32) with hand-computed expectations.
module tb_kamus_lsu;
  import kamus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  lsu_op_e     op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_addr_i;
  logic        kill_i;
  logic        busy_o;
  logic        done_valid_o;
  logic [31:0] rdata_o;
  logic [4:0]  rd_addr_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;

  int n_checks = 0;
  int n_err    = 0;

  kamus_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i), .kill_i(kill_i),
    .busy_o(busy_o), .done_valid_o(done_valid_o), .rdata_o(rdata_o),
    .rd_addr_o(rd_addr_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present an op in IDLE for one cycle; returns one step later (state REQ or ERR).
  task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input string tag);
    req_valid_i = 1'b1;
    op_i        = op;
    addr_i      = addr;
    wdata_i     = wd;
    rd_addr_i   = rd;
    #1;
    chk({tag, ".busy_acc"}, busy_o, 1);
    step();
    req_valid_i = 1'b0;
    op_i        = OP_NONE;
  endtask

  // Called in REQ; returns in the done cycle.
  task automatic mem_xact(input int gnt_wait, input int rv_wait, input logic [31:0] rdat,
                          input logic err, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic exp_we, input logic [31:0] exp_wdata, input string tag);
    for (int i = 0; i <= gnt_wait; i++) begin
      dmem_gnt_i = (i == gnt_wait);
      #1;
      chk({tag, ".req"},   dmem_req_o,   1);
      chk({tag, ".addr"},  dmem_addr_o,  exp_addr);
      chk({tag, ".be"},    dmem_be_o,    exp_be);
      chk({tag, ".we"},    dmem_we_o,    exp_we);
      chk({tag, ".wdata"}, dmem_wdata_o, exp_wdata);
      chk({tag, ".busy_req"}, busy_o, 1);
      step();
    end
    dmem_gnt_i = 1'b0;
    for (int i = 0; i <= rv_wait; i++) begin
      dmem_rvalid_i = (i == rv_wait);
      dmem_rdata_i  = (i == rv_wait) ? rdat : 32'h0;
      dmem_err_i    = (i == rv_wait) ? err : 1'b0;
      #1;
      chk({tag, ".req_resp"},  dmem_req_o, 0);
      chk({tag, ".busy_resp"}, busy_o, 1);
      step();
    end
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    dmem_err_i    = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [31:0] exp_rdata, input logic [4:0] exp_rd,
                          input logic exp_mis, input logic exp_berr);
    chk({tag, ".done"},  done_valid_o, 1);
    chk({tag, ".rdata"}, rdata_o,      exp_rdata);
    chk({tag, ".rd"},    rd_addr_o,    exp_rd);
    chk({tag, ".mis"},   misaligned_o, exp_mis);
    chk({tag, ".berr"},  bus_err_o,    exp_berr);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; op_i = OP_NONE; addr_i = '0; wdata_i = '0;
    rd_addr_i = '0; kill_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0; dmem_err_i = 1'b0;
    step();
    step();
    chk("rst.busy",  busy_o, 0);
    chk("rst.done",  done_valid_o, 0);
    chk("rst.rdata", rdata_o, 0);
    chk("rst.rd",    rd_addr_o, 0);
    chk("rst.mis",   misaligned_o, 0);
    chk("rst.berr",  bus_err_o, 0);
    chk("rst.req",   dmem_req_o, 0);
    chk("rst.we",    dmem_we_o, 0);
    chk("rst.be",    dmem_be_o, 0);
    chk("rst.addr",  dmem_addr_o, 0);
    chk("rst.wdata", dmem_wdata_o, 0);
    rst_i = 1'b0;
    step();

    // LB, sign-extended top byte
    issue(OP_LB, 32'h1003, 32'h0, 5'd5, "lb");
    mem_xact(0, 0, 32'h80FF_0000, 1'b0, 32'h1000, 4'h8, 1'b0, 32'h0, "lb");
    chk_done("lb", 32'hFFFF_FF80, 5'd5, 1'b0, 1'b0);
    chk("lb.busy_t3", busy_o, 0);

    // LHU back-to-back in the done cycle
    issue(OP_LHU, 32'h2002, 32'h0, 5'd7, "lhu");
    mem_xact(0, 0, 32'hBEEF_1234, 1'b0, 32'h2000, 4'hC, 1'b0, 32'h0, "lhu");
    chk_done("lhu", 32'h0000_BEEF, 5'd7, 1'b0, 1'b0);
    step();
    chk("lhu.done_clr", done_valid_o, 0);

    // SH to upper half
    issue(OP_SH, 32'h3002, 32'h0000_ABCD, 5'd0, "sh");
    mem_xact(0, 1, 32'hFFFF_FFFF, 1'b0, 32'h3000, 4'hC, 1'b1, 32'hABCD_0000, "sh");
    chk_done("sh", 32'h0, 5'd0, 1'b0, 1'b0);
    step();

    // Misaligned LW, with a stray grant that must be ignored
    issue(OP_LW, 32'h4001, 32'h0, 5'd9, "mis");
    dmem_gnt_i = 1'b1;
    #1;
    chk("mis.no_req", dmem_req_o, 0);
    chk("mis.busy",   busy_o, 1);
    chk("mis.done_t1", done_valid_o, 0);
    step();
    dmem_gnt_i = 1'b0;
    chk_done("mis", 32'h0, 5'd9, 1'b1, 1'b0);
    step();
    chk("mis.idle_req",  dmem_req_o, 0);
    chk("mis.idle_done", done_valid_o, 0);

    // Delayed grant, error response
    issue(OP_LW, 32'h5000, 32'h0, 5'd3, "err");
    mem_xact(3, 0, 32'hDEAD_BEEF, 1'b1, 32'h5000, 4'hF, 1'b0, 32'h0, "err");
    chk_done("err", 32'h0, 5'd3, 1'b0, 1'b1);
    step();

    // Kill in ERR suppresses completion
    issue(OP_LH, 32'h0001, 32'h0, 5'd4, "kerr");
    kill_i = 1'b1;
    #1;
    chk("kerr.busy", busy_o, 0);
    step();
    kill_i = 1'b0;
    chk("kerr.done", done_valid_o, 0);
    chk("kerr.mis",  misaligned_o, 0);

    // Kill in IDLE blocks acceptance
    req_valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h8000; kill_i = 1'b1;
    #1;
    chk("kidle.busy", busy_o, 0);
    step();
    req_valid_i = 1'b0; op_i = OP_NONE; kill_i = 1'b0;
    #1;
    chk("kidle.req", dmem_req_o, 0);
    chk("kidle.busy_after", busy_o, 0);

    // Kill after grant, drain, then a waiting LW proceeds
    issue(OP_LW, 32'h6000, 32'h0, 5'd10, "kill");
    dmem_gnt_i = 1'b1;
    #1;
    chk("kill.req", dmem_req_o, 1);
    step();
    dmem_gnt_i = 1'b0;
    kill_i = 1'b1;
    #1;
    chk("kill.busy_kill", busy_o, 0);
    step();
    kill_i = 1'b0;
    req_valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h7000; rd_addr_i = 5'd11;
    #1;
    chk("drain.busy1", busy_o, 1);
    chk("drain.req1",  dmem_req_o, 0);
    chk("drain.done1", done_valid_o, 0);
    step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("drain.busy2", busy_o, 1);
    chk("drain.req2",  dmem_req_o, 0);
    step();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    #1;
    chk("drain.no_done", done_valid_o, 0);
    chk("drain.req3",    dmem_req_o, 0);
    chk("drain.busy3",   busy_o, 1);
    step();
    req_valid_i = 1'b0; op_i = OP_NONE;
    mem_xact(0, 0, 32'h1234_5678, 1'b0, 32'h7000, 4'hF, 1'b0, 32'h0, "lw2");
    chk_done("lw2", 32'h1234_5678, 5'd11, 1'b0, 1'b0);
    step();

    // Reset mid-operation returns to IDLE immediately
    issue(OP_LW, 32'h9000, 32'h0, 5'd1, "rmid");
    #1;
    chk("rmid.req_before", dmem_req_o, 1);
    rst_i = 1'b1;
    #1;
    chk("rmid.req", dmem_req_o, 0);
    chk("rmid.busy", busy_o, 0);
    rst_i = 1'b0;
    step();
    chk("rmid.req_after", dmem_req_o, 0);
    chk("rmid.done", done_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
